// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART serializer; writes into a full FIFO are dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;

  // full gates the write even when a pop lands on the same edge
  assign push    = wen && !full_q;
  assign pop     = ren && !empty_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a write FIFO; frames are sent back-to-back while data is queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          tx_wen,
  input  logic [7:0]                    uart_din,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q;
  logic [BW-1:0]  baud_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q, busy_q;

  logic [7:0]     fifo_head;
  logic           fifo_empty;
  logic           bit_end, frame_gap, fifo_pop, push, idle_next, nonempty_next;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (Rst),
    .wen   (tx_wen),
    .wdata (uart_din),
    .ren   (fifo_pop),
    .rdata (fifo_head),
    .full  (tx_full),
    .empty (fifo_empty),
    .count (tx_count)
  );

  assign bit_end   = (baud_q == BAUD_LAST);
  // a new byte may be taken while idle or as the stop bit completes
  assign frame_gap = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign fifo_pop  = frame_gap && !fifo_empty;
  assign idle_next = frame_gap && fifo_empty;
  assign push      = tx_wen && !tx_full;
  assign nonempty_next = push || (tx_count > CW'(fifo_pop));

  // tx is registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= !idle_next || nonempty_next;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!fifo_empty) begin
            shift_q <= fifo_head;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; a line monitor decodes frames at mid-bit.
module tb_uart_tx;

  logic       clk, Rst, tx_wen;
  logic [7:0] uart_din;
  logic       tx_full, tx_busy, tx;
  logic [3:0] tx_count;

  int n_cmp = 0;
  int n_err = 0;
  int x_err = 0;
  int cyc   = 0;
  bit armed = 0;

  logic [9:0] rx_q[$];
  int         starts[$];

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .tx_wen   (tx_wen),
    .uart_din (uart_din),
    .tx_full  (tx_full),
    .tx_busy  (tx_busy),
    .tx_count (tx_count),
    .tx       (tx)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line monitor: frame starts at the first low sample, bit k sampled 4k+2 cycles later
  initial begin
    bit         rst_e;
    bit         mon_act;
    int         mon_cnt;
    logic [9:0] mon_bits;
    mon_act  = 0;
    mon_cnt  = 0;
    mon_bits = '0;
    forever begin
      @(posedge clk);
      rst_e = Rst;
      @(negedge clk);
      if (armed && !rst_e && $isunknown(tx)) x_err++;
      if (rst_e) mon_act = 0;
      else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act  = 1;
          mon_cnt  = 0;
          mon_bits = '0;
          starts.push_back(cyc);
        end
      end else mon_cnt++;
      if (mon_act && (mon_cnt % 4 == 2)) mon_bits[mon_cnt/4] = tx;
      if (mon_act && mon_cnt == 38) begin
        rx_q.push_back(mon_bits);
        mon_act = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    tx_wen   = 1'b1;
    uart_din = d;
    tick;
    tx_wen   = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int done_cyc);
    int k;
    k = 0;
    while (tx_busy !== 1'b0 && k < bound) begin
      tick;
      k++;
    end
    chk("idle_timeout", {31'd0, tx_busy}, 0);
    done_cyc = cyc;
  endtask

  task automatic clear_mon;
    rx_q.delete();
    starts.delete();
  endtask

  initial begin
    logic [9:0] fa5;
    logic [9:0] fexp;
    logic [7:0] b;
    int cyc_m, done;

    Rst = 1; tx_wen = 0; uart_din = 8'h00;
    tick; tick; tick;
    chk("rst_tx", tx, 1);
    chk("rst_count", tx_count, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    Rst = 0;
    armed = 1;
    tick;

    // single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 (index 0 = start bit)
    clear_mon;
    fa5 = 10'b1101001010;
    wr(8'hA5);
    chk("a5_count_n", tx_count, 1);
    chk("a5_busy_n", tx_busy, 1);
    chk("a5_tx_n", tx, 1);
    tick;
    chk("a5_tx_n1", tx, 1);
    chk("a5_count_n1", tx_count, 0);
    tick;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("a5_bit%0d_c%0d", k, c), tx, fa5[k]);
        if (k == 9 && c == 2) chk("a5_busy_hold", tx_busy, 1);
        if (k == 9 && c == 3) chk("a5_busy_drop", tx_busy, 0);
        tick;
      end
    end
    chk("a5_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_frame", rx_q[0], fa5);

    // burst 0x00, 0xFF, 0x55
    clear_mon;
    wr(8'h00);
    cyc_m = cyc;
    chk("burst_count0", tx_count, 1);
    wr(8'hFF);
    chk("burst_count1", tx_count, 1);
    wr(8'h55);
    chk("burst_count2", tx_count, 2);
    wait_idle(300, done);
    chk("burst_len", done - cyc_m, 121);
    chk("burst_nframes", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("burst_f0", rx_q[0], 10'b1_00000000_0);
      chk("burst_f1", rx_q[1], 10'b1_11111111_0);
      chk("burst_f2", rx_q[2], 10'b1_01010101_0);
    end
    if (starts.size() == 3) begin
      chk("burst_first_fall", starts[0] - cyc_m, 2);
      chk("burst_gap01", starts[1] - starts[0], 40);
      chk("burst_gap12", starts[2] - starts[1], 40);
    end
    tick;

    // overflow: 0x10..0x19, last one dropped
    clear_mon;
    for (int i = 0; i < 10; i++) begin
      b = 8'h10 + 8'(i);
      wr(b);
    end
    chk("ovf_full", tx_full, 1);
    chk("ovf_count", tx_count, 8);
    wait_idle(600, done);
    chk("ovf_nframes", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      b = 8'h10 + 8'(i);
      fexp = {1'b1, b, 1'b0};
      chk($sformatf("ovf_f%0d", i), rx_q[i], fexp);
    end
    tick;

    // full FIFO with a pop on the same edge as a write of 0x77
    clear_mon;
    for (int i = 0; i < 9; i++) begin
      b = 8'h20 + 8'(i);
      wr(b);
    end
    chk("fp_full", tx_full, 1);
    chk("fp_count8", tx_count, 8);
    for (int i = 0; i < 32; i++) tick;
    chk("fp_count_before", tx_count, 8);
    wr(8'h77);
    chk("fp_count_after", tx_count, 7);
    chk("fp_full_after", tx_full, 0);
    tick;
    chk("fp_count_hold", tx_count, 7);
    wait_idle(600, done);
    chk("fp_nframes", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      b = 8'h20 + 8'(i);
      fexp = {1'b1, b, 1'b0};
      chk($sformatf("fp_f%0d", i), rx_q[i], fexp);
    end
    tick;

    // reset during data bit 3 of 0xC3, with 0x99 still queued
    clear_mon;
    wr(8'hC3);
    wr(8'h99);
    for (int i = 0; i < 17; i++) tick;
    chk("rst_pre_tx_bit3", tx, 0);
    chk("rst_pre_count", tx_count, 1);
    Rst = 1; tx_wen = 1; uart_din = 8'hEE;
    tick;
    Rst = 0; tx_wen = 0;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_count", tx_count, 0);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_full", tx_full, 0);
    tick;
    chk("rst_post_tx", tx, 1);
    chk("rst_post_count", tx_count, 0);
    chk("rst_post_busy", tx_busy, 0);
    clear_mon;
    wr(8'h3C);
    wait_idle(300, done);
    chk("rst_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rst_3c_frame", rx_q[0], 10'b1_00111100_0);
    tick;

    chk("tx_no_x", x_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
